grey_fifo_wr_ctrl: RTL and testbench

GREY_FIFO_WR_CTRL -- requirements
Module: grey_fifo_wr_ctrl

---
 rtl/grey_pkg.sv | 20 ++
 rtl/GreyEncode.sv | 11 +
 rtl/PanicModule.sv | 10 +
 rtl/grey_fifo_wr_ctrl.sv | 85 ++++++++
 tb/tb_grey_fifo_wr_ctrl.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/grey_pkg.sv
// rtl/grey_pkg.sv - shared Grey-code helpers for the FIFO pointer logic
package grey_pkg;

  // Widest pointer the decode helper handles; narrower pointers are zero-extended.
  localparam int GREY_MAX_W = 8;

  function automatic int pw(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic logic [GREY_MAX_W-1:0] grey2bin(input logic [GREY_MAX_W-1:0] g);
    logic [GREY_MAX_W-1:0] b;
    b[GREY_MAX_W-1] = g[GREY_MAX_W-1];
    for (int i = GREY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/GreyEncode.sv
// rtl/GreyEncode.sv - combinational binary-to-Grey converter
module GreyEncode #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] grey
);

  assign grey = bin ^ (bin >> 1);

endmodule

// File: rtl/PanicModule.sv
// rtl/PanicModule.sv - stops elaboration when instantiated with TRIGGER set
module PanicModule #(
  parameter bit TRIGGER = 1'b0
) ();

  if (TRIGGER) begin : g_fire
    $fatal(1, "grey_fifo_wr_ctrl: ADDR_W must be in 1..3");
  end

endmodule

// File: rtl/grey_fifo_wr_ctrl.sv
// rtl/grey_fifo_wr_ctrl.sv - write-side controller of an async FIFO with Grey pointers
module grey_fifo_wr_ctrl
  import grey_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int AFULL  = 2**ADDR_W - 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  output logic                    mem_we_o,
  output logic [ADDR_W-1:0]       mem_waddr_o,
  input  logic [pw(ADDR_W)-1:0]   rptr_grey_i,
  output logic [pw(ADDR_W)-1:0]   wptr_grey_o,
  output logic                    full_o,
  output logic                    afull_o,
  output logic [pw(ADDR_W)-1:0]   level_o,
  output logic                    err_o
);

  localparam int              PW      = pw(ADDR_W);
  localparam logic [PW-1:0]   DEPTH   = PW'(2**ADDR_W);
  localparam logic [31:0]     AFULL_U = 32'(AFULL);

  logic [PW-1:0]         wptr_bin;
  logic [PW-1:0]         wptr_bin_next;
  logic [PW-1:0]         wptr_grey_next;
  logic [PW-1:0]         rptr_bin;
  logic [PW-1:0]         rptr_prev;
  logic [PW-1:0]         level_next;
  logic [PW-1:0]         rdiff;
  logic [GREY_MAX_W-1:0] rptr_dec;
  logic                  accept;
  logic                  multi_bit;
  logic                  over_depth;
  logic                  unused_dec;

  if (ADDR_W < 1 || ADDR_W > 3) begin : g_panic
    PanicModule #(.TRIGGER(1'b1)) u_panic ();
  end

  // Ready is gated by reset so a write offered during reset is never taken.
  assign wr_ready_o    = !full_o && !rst_i;
  assign accept        = wr_valid_i && wr_ready_o;
  assign mem_we_o      = accept;
  assign mem_waddr_o   = wptr_bin[ADDR_W-1:0];
  assign wptr_bin_next = wptr_bin + PW'(accept);

  assign rptr_dec   = grey2bin(GREY_MAX_W'(rptr_grey_i));
  assign rptr_bin   = rptr_dec[PW-1:0];
  assign unused_dec = &{1'b0, rptr_dec[GREY_MAX_W-1:PW]};
  assign level_next = wptr_bin_next - rptr_bin;

  // A synchronised Grey pointer may move at most one bit per sample.
  assign rdiff      = rptr_prev ^ rptr_grey_i;
  assign multi_bit  = |(rdiff & (rdiff - PW'(1)));
  assign over_depth = level_next > DEPTH;

  GreyEncode #(.WIDTH(PW)) u_grey_enc (
    .bin  (wptr_bin_next),
    .grey (wptr_grey_next)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_bin    <= '0;
      wptr_grey_o <= '0;
      rptr_prev   <= '0;
      full_o      <= 1'b0;
      afull_o     <= (AFULL == 0);
      level_o     <= '0;
      err_o       <= 1'b0;
    end else begin
      wptr_bin    <= wptr_bin_next;
      wptr_grey_o <= wptr_grey_next;
      rptr_prev   <= rptr_grey_i;
      full_o      <= (level_next == DEPTH);
      afull_o     <= ({{(32-PW){1'b0}}, level_next} >= AFULL_U);
      level_o     <= level_next;
      err_o       <= err_o || multi_bit || over_depth;
    end
  end

endmodule

// File: tb/tb_grey_fifo_wr_ctrl.sv
// tb/tb_grey_fifo_wr_ctrl.sv - directed self-checking bench for grey_fifo_wr_ctrl
module tb_grey_fifo_wr_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       wr_valid_i;
  logic       wr_ready_o;
  logic       mem_we_o;
  logic [1:0] mem_waddr_o;
  logic [2:0] rptr_grey_i;
  logic [2:0] wptr_grey_o;
  logic       full_o;
  logic       afull_o;
  logic [2:0] level_o;
  logic       err_o;

  int errors = 0;
  int checks = 0;

  logic [2:0] gtab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
  logic [2:0] fill_grey [4] = '{3'b001, 3'b011, 3'b010, 3'b110};

  grey_fifo_wr_ctrl #(.ADDR_W(2), .AFULL(3)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .mem_we_o    (mem_we_o),
    .mem_waddr_o (mem_waddr_o),
    .rptr_grey_i (rptr_grey_i),
    .wptr_grey_o (wptr_grey_o),
    .full_o      (full_o),
    .afull_o     (afull_o),
    .level_o     (level_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wgrey"}, 32'(wptr_grey_o), 32'h0);
    check({tag, "_level"}, 32'(level_o), 32'h0);
    check({tag, "_full"},  32'(full_o), 32'h0);
    check({tag, "_afull"}, 32'(afull_o), 32'h0);
    check({tag, "_err"},   32'(err_o), 32'h0);
  endtask

  initial begin
    rst_i       = 1'b1;
    wr_valid_i  = 1'b1;
    rptr_grey_i = 3'b000;

    // Reset held: write offer must be refused.
    @(negedge clk_i);
    check("rst_ready", 32'(wr_ready_o), 32'h0);
    check("rst_we",    32'(mem_we_o), 32'h0);
    check_reset_values("rst_hold");
    wr_valid_i = 1'b0;
    rst_i      = 1'b0;
    #1;
    check_reset_values("rst_rel");
    check("rst_rel_ready", 32'(wr_ready_o), 32'h1);

    // Fill the FIFO with the read pointer parked at zero.
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      wr_valid_i = 1'b1;
      #1;
      check($sformatf("fill%0d_we", i),    32'(mem_we_o), 32'h1);
      check($sformatf("fill%0d_waddr", i), 32'(mem_waddr_o), 32'(i));
      @(negedge clk_i);
      check($sformatf("fill%0d_wgrey", i), 32'(wptr_grey_o), 32'(fill_grey[i]));
      check($sformatf("fill%0d_level", i), 32'(level_o), 32'(i + 1));
      check($sformatf("fill%0d_afull", i), 32'(afull_o), 32'(i >= 2));
      check($sformatf("fill%0d_full", i),  32'(full_o), 32'(i == 3));
    end
    #1;
    check("full_ready", 32'(wr_ready_o), 32'h0);
    check("full_we",    32'(mem_we_o), 32'h0);
    @(negedge clk_i);
    check("full_hold_wgrey", 32'(wptr_grey_o), 32'b110);
    check("full_hold_level", 32'(level_o), 32'h4);

    // One read frees a slot.
    rptr_grey_i = 3'b001;
    @(negedge clk_i);
    check("rd1_full",  32'(full_o), 32'h0);
    check("rd1_level", 32'(level_o), 32'h3);
    check("rd1_ready", 32'(wr_ready_o), 32'h1);

    // Reset asserted between edges while a burst is running.
    @(posedge clk_i);
    #3;
    check("burst_wgrey", 32'(wptr_grey_o), 32'b111);
    rst_i = 1'b1;
    #1;
    check_reset_values("async");
    check("async_ready", 32'(wr_ready_o), 32'h0);
    check("async_we",    32'(mem_we_o), 32'h0);
    wr_valid_i  = 1'b0;
    rptr_grey_i = 3'b000;
    @(negedge clk_i);
    rst_i = 1'b0;

    // Eight writes with the reader tracking, covering pointer wrap.
    for (int k = 0; k < 8; k++) begin
      rptr_grey_i = gtab[k];
      wr_valid_i  = 1'b1;
      #1;
      check($sformatf("trk%0d_we", k),    32'(mem_we_o), 32'h1);
      check($sformatf("trk%0d_waddr", k), 32'(mem_waddr_o), 32'(k % 4));
      @(negedge clk_i);
      check($sformatf("trk%0d_level", k), 32'(level_o), 32'h1);
      check($sformatf("trk%0d_full", k),  32'(full_o), 32'h0);
      check($sformatf("trk%0d_err", k),   32'(err_o), 32'h0);
    end
    wr_valid_i = 1'b0;
    check("trk_wgrey_wrap", 32'(wptr_grey_o), 32'b000);

    // Reader catches up, then jumps two Grey bits at once.
    rptr_grey_i = 3'b000;
    @(negedge clk_i);
    check("pre_err_err",   32'(err_o), 32'h0);
    check("pre_err_level", 32'(level_o), 32'h0);
    rptr_grey_i = 3'b011;
    @(negedge clk_i);
    check("jump_err", 32'(err_o), 32'h1);
    rptr_grey_i = 3'b000;
    repeat (3) @(negedge clk_i);
    check("sticky_err",   32'(err_o), 32'h1);
    check("sticky_level", 32'(level_o), 32'h0);
    check("sticky_ready", 32'(wr_ready_o), 32'h1);

    rst_i = 1'b1;
    #1;
    check("err_clr", 32'(err_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_err", 32'(err_o), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
